irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised successor to the fixed three-source interrupt unit. Supports N_IRQ sources, per-source enable and edge/level mode, and fixed priority (lowest index wins).
- Claim/complete handshake toward the multi-cycle CPU's eip/eip_reply pair.
- Sits on the mmapper peripheral bus with the usual a/d/we/spo slave interface; spo is a combinational read.

Parameters:
- N_IRQ, 8, number of interrupt sources (1..31).
- ID_W, 5, width of a source ID field; IDs are reported as index+1, 0 = none.

Ports:
- clk  in  1  system clock (clk_main domain).
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt requests, bit i = source i.
- interrupt  out  1  to CPU eip.
- int_reply  in  1  one-cycle CPU acknowledge (eip_reply).
- a  in  3  word register select.
- d  in  32  write data.
- we  in  1  write strobe, one cycle per write.
- spo  out  32  read data, combinational from a.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - interrupt=0, state=IDLE.
  - ENABLE=0, MODE=0 (all level), PENDING=0, CUR_ID=0.
  - Edge-detect history = 0.
- Register map:
  - 0 ENABLE (rw).
  - 1 PENDING (r; write-1-to-clear, edge sources only, level bits ignore clear).
  - 2 MODE (rw, 1=rising-edge, 0=level).
  - 3 CLAIM (r: CUR_ID zero-extended).
  - 4 COMPLETE (w: any write with d[ID_W-1:0]==CUR_ID ends service; a mismatched ID is ignored).
  - 5 INFO (r: {16'h0, 8'(N_IRQ), 8'h01}).
  - 6 and 7 read 0, writes ignored.
- Bits above N_IRQ: read 0, writes ignored.
- Pending update, registered each cycle:
  - Edge source: set when irq_s & ~irq_prev. Cleared by PENDING W1C or by its own claim.
  - Level source: PENDING bit = irq_s (live, registered).
- Simultaneous set and clear on one edge bit in the same cycle: set wins.
- Priority encoder: the lowest index i with PENDING[i] & ENABLE[i] is the winner. best_id = i+1, or 0 if none.
- FSM:
  - IDLE: if best_id!=0, go to SIGNAL and set interrupt=1 (registered, asserted the cycle after pending is visible).
  - SIGNAL: on int_reply:
    - CUR_ID <= best_id sampled in that cycle; clear the winner's edge pending; interrupt <= 0; go to SERVICE.
    - If best_id has dropped to 0 (level deasserted or disabled) before reply: CUR_ID <= 0, interrupt <= 0, go to IDLE (spurious).
  - SERVICE: interrupt held 0. A matching COMPLETE write sets CUR_ID <= 0 and returns to IDLE. There is no nesting.
- Latency: irq_in high during cycle k (no sync) gives PENDING at edge k+1 and interrupt high at edge k+2.
- int_reply outside SIGNAL is ignored.
- ENABLE written to 0 while in SIGNAL: interrupt stays high until reply, which then takes the spurious path.
- rst mid-service: everything returns to the reset values; in-flight edges are lost.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq_in passes through a 2-flop synchroniser (reset 0) before edge detection and pending. Latency grows by 2 cycles: PENDING at k+3, interrupt at k+4.
- Undefined: irq_s = irq_in directly; sources must be synchronous to clk.

Decomposition:
- Shared package irq_pkg holds:
  - Register offsets: IRQ_REG_ENABLE..IRQ_REG_INFO.
  - FSM state encoding: IDLE/SIGNAL/SERVICE, 2 bits.
  - INFO version constant.
- One sub-module: irq_prio_enc. Parameter N, input vector, outputs id (index+1) and valid.

Test Plan:
- Edge source:
  - Stimulus: reset; ENABLE=8'h04, MODE=8'h04; pulse irq_in[2] for 1 cycle.
  - Response: PENDING=8'h04; interrupt high 2 cycles later (no sync).
  - Then int_reply: CLAIM=3, PENDING=0, interrupt=0.
  - Then write COMPLETE=3: state IDLE.
- Priority:
  - Stimulus: ENABLE=8'hFF, all level; hold irq_in=8'b1010_0000, then reply.
  - Response: CLAIM=6.
  - After COMPLETE=6 and a further reply: CLAIM=6 again (level still high).
  - After dropping bit 5 and replying: CLAIM=8.
- Spurious:
  - Stimulus: level source 1 enabled, interrupt high; deassert irq_in[1] before the reply; then reply.
  - Response: CLAIM=0, interrupt=0, state IDLE.
- Edge set wins:
  - Stimulus: write PENDING W1C=8'h01 in the same cycle as a rising edge on irq_in[0] (edge mode).
  - Response: PENDING[0]=1.
- Wrong complete:
  - Stimulus: in SERVICE with CUR_ID=3, write COMPLETE=2.
  - Response: remains in SERVICE; new pending does not raise interrupt.
  - Then COMPLETE=3: returns to IDLE.
- Reset mid-operation:
  - Stimulus: assert rst during SIGNAL.
  - Response: next cycle interrupt=0, ENABLE/MODE/PENDING=0, INFO reads 32'h0000_0801 (N_IRQ=8).

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM encoding, INFO version.
package irq_pkg;

  localparam logic [2:0] IRQ_REG_ENABLE   = 3'd0;
  localparam logic [2:0] IRQ_REG_PENDING  = 3'd1;
  localparam logic [2:0] IRQ_REG_MODE     = 3'd2;
  localparam logic [2:0] IRQ_REG_CLAIM    = 3'd3;
  localparam logic [2:0] IRQ_REG_COMPLETE = 3'd4;
  localparam logic [2:0] IRQ_REG_INFO     = 3'd5;

  localparam logic [7:0] IRQ_INFO_VERSION = 8'h01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, reported as index+1 (0 = none).
module irq_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] id_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest requesting index is written last.
  always_comb begin
    id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IW'(i + 1);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// N-source interrupt controller with claim/complete handshake and mmapper slave port.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on irq_in (adds 2 cycles of latency).
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             interrupt,
  input  logic             int_reply,
  input  logic [2:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo
);

  logic [N_IRQ-1:0] irq_s;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] enable_q;
  logic [N_IRQ-1:0] mode_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] w1c_mask, claim_mask;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;
  logic [ID_W-1:0]  best_id;
  logic             best_valid;
  logic             interrupt_q, interrupt_d;
  logic             claim_take, complete_hit;
  irq_state_e       state_q, state_d;
  logic             unused_d;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign unused_d = ^d;

  irq_prio_enc #(
    .N  (N_IRQ),
    .IW (ID_W)
  ) u_prio (
    .req_i   (pending_q & enable_q),
    .id_o    (best_id),
    .valid_o (best_valid)
  );

  assign claim_take   = (state_q == SIGNAL) && int_reply && best_valid;
  assign complete_hit = we && (a == IRQ_REG_COMPLETE) && (d[ID_W-1:0] == cur_id_q);
  assign w1c_mask     = (we && (a == IRQ_REG_PENDING)) ? d[N_IRQ-1:0] : '0;

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      claim_mask[i] = claim_take && (best_id == ID_W'(i + 1));
    end
  end

  // Edge bits: clears are applied before the new rising edge is ORed in, so set wins.
  assign pending_d = (mode_q & ((pending_q & ~(w1c_mask | claim_mask)) | (irq_s & ~irq_prev_q)))
                   | (~mode_q & irq_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      if (we && (a == IRQ_REG_ENABLE)) enable_q <= d[N_IRQ-1:0];
      if (we && (a == IRQ_REG_MODE))   mode_q   <= d[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_id_q    <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      interrupt_q <= interrupt_d;
    end
  end

  // A reply with no surviving winner is spurious and drops straight back to IDLE.
  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    interrupt_d = interrupt_q;
    case (state_q)
      IDLE: begin
        if (best_valid) begin
          state_d     = SIGNAL;
          interrupt_d = 1'b1;
        end
      end
      SIGNAL: begin
        if (int_reply) begin
          interrupt_d = 1'b0;
          if (best_valid) begin
            cur_id_d = best_id;
            state_d  = SERVICE;
          end else begin
            cur_id_d = '0;
            state_d  = IDLE;
          end
        end
      end
      SERVICE: begin
        interrupt_d = 1'b0;
        if (complete_hit) begin
          cur_id_d = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cur_id_d    = '0;
        interrupt_d = 1'b0;
      end
    endcase
  end

  assign interrupt = interrupt_q;

  always_comb begin
    spo = '0;
    case (a)
      IRQ_REG_ENABLE:  spo[N_IRQ-1:0] = enable_q;
      IRQ_REG_PENDING: spo[N_IRQ-1:0] = pending_q;
      IRQ_REG_MODE:    spo[N_IRQ-1:0] = mode_q;
      IRQ_REG_CLAIM:   spo[ID_W-1:0]  = cur_id_q;
      IRQ_REG_INFO:    spo = {16'h0, 8'(N_IRQ), IRQ_INFO_VERSION};
      default:         spo = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller (default build, N_IRQ=8, no synchroniser).
module tb_irq_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  irqIn;
  logic        interrupt;
  logic        intReply;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic [31:0] spo;

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;

  irq_controller #(
    .N_IRQ (8),
    .ID_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irqIn),
    .interrupt (interrupt),
    .int_reply (intReply),
    .a         (a),
    .d         (d),
    .we        (we),
    .spo       (spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] expected);
    a = addr;
    #1;
    checkOutput(tag, spo, expected);
  endtask

  task automatic applyStimulus(input logic inWe, input logic [2:0] inA, input logic [31:0] inD,
                               input logic inReply);
    we       = inWe;
    a        = inA;
    d        = inD;
    intReply = inReply;
    tick();
    we       = 1'b0;
    intReply = 1'b0;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 1'b0);
  endtask

  task automatic reply();
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; irqIn = '0; intReply = 1'b0; a = '0; d = '0; we = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("reset_interrupt", {31'h0, interrupt}, 32'h0);
    readCheck("reset_enable", 3'd0, 32'h0);
    readCheck("reset_pending", 3'd1, 32'h0);
    readCheck("reset_mode", 3'd2, 32'h0);
    readCheck("reset_claim", 3'd3, 32'h0);
    readCheck("reset_info", 3'd5, 32'h0000_0801);

    // Edge source 2
    $display("[TB] edge source");
    writeReg(3'd0, 32'h04);
    writeReg(3'd2, 32'h04);
    irqIn = 8'h04;
    tick();
    irqIn = 8'h00;
    readCheck("edge_pending", 3'd1, 32'h04);
    checkOutput("edge_irq_early", {31'h0, interrupt}, 32'h0);
    tick();
    checkOutput("edge_irq_high", {31'h0, interrupt}, 32'h1);
    reply();
    readCheck("edge_claim", 3'd3, 32'h3);
    readCheck("edge_pending_clr", 3'd1, 32'h0);
    checkOutput("edge_irq_low", {31'h0, interrupt}, 32'h0);
    writeReg(3'd4, 32'h3);
    readCheck("edge_complete", 3'd3, 32'h0);

    // Priority among level sources, upper ENABLE bits dropped
    $display("[TB] priority");
    writeReg(3'd0, 32'hFFFF_FFFF);
    readCheck("enable_mask", 3'd0, 32'h0000_00FF);
    readCheck("reg6_zero", 3'd6, 32'h0);
    writeReg(3'd2, 32'h0);
    irqIn = 8'hA0;
    tick();
    tick();
    checkOutput("prio_irq_high", {31'h0, interrupt}, 32'h1);
    reply();
    readCheck("prio_claim6", 3'd3, 32'h6);
    writeReg(3'd4, 32'h6);
    tick();
    checkOutput("prio_rearm", {31'h0, interrupt}, 32'h1);
    reply();
    readCheck("prio_claim6_again", 3'd3, 32'h6);
    writeReg(3'd4, 32'h6);
    irqIn = 8'h80;
    tick();
    tick();
    reply();
    readCheck("prio_claim8", 3'd3, 32'h8);
    irqIn = 8'h00;
    writeReg(3'd4, 32'h8);
    tick();
    checkOutput("prio_idle", {31'h0, interrupt}, 32'h0);

    // Spurious: level source 1 drops before reply
    $display("[TB] spurious");
    writeReg(3'd0, 32'h02);
    irqIn = 8'h02;
    tick();
    tick();
    checkOutput("spur_irq_high", {31'h0, interrupt}, 32'h1);
    irqIn = 8'h00;
    tick();
    reply();
    readCheck("spur_claim", 3'd3, 32'h0);
    checkOutput("spur_irq_low", {31'h0, interrupt}, 32'h0);
    irqIn = 8'h02;
    tick();
    tick();
    checkOutput("spur_back_idle", {31'h0, interrupt}, 32'h1);
    reply();
    readCheck("spur_claim2", 3'd3, 32'h2);
    irqIn = 8'h00;
    writeReg(3'd4, 32'h2);
    tick();

    // Edge set wins over same-cycle W1C, then plain W1C clears
    $display("[TB] edge set wins");
    writeReg(3'd0, 32'h01);
    writeReg(3'd2, 32'h01);
    irqIn = 8'h01;
    writeReg(3'd1, 32'h01);
    readCheck("setwins_pending", 3'd1, 32'h01);
    writeReg(3'd1, 32'h01);
    readCheck("w1c_pending", 3'd1, 32'h00);
    checkOutput("w1c_irq_high", {31'h0, interrupt}, 32'h1);
    reply();
    readCheck("w1c_spur_claim", 3'd3, 32'h0);
    checkOutput("w1c_spur_irq", {31'h0, interrupt}, 32'h0);
    irqIn = 8'h00;
    tick();

    // Wrong complete is ignored while in service
    $display("[TB] wrong complete");
    writeReg(3'd0, 32'h05);
    writeReg(3'd2, 32'h05);
    irqIn = 8'h04;
    tick();
    irqIn = 8'h00;
    tick();
    reply();
    readCheck("wc_claim3", 3'd3, 32'h3);
    writeReg(3'd4, 32'h2);
    readCheck("wc_still3", 3'd3, 32'h3);
    irqIn = 8'h01;
    tick();
    irqIn = 8'h00;
    tick();
    tick();
    checkOutput("wc_no_irq", {31'h0, interrupt}, 32'h0);
    readCheck("wc_pending", 3'd1, 32'h01);
    writeReg(3'd4, 32'h3);
    readCheck("wc_done", 3'd3, 32'h0);
    tick();
    checkOutput("wc_idle_irq", {31'h0, interrupt}, 32'h1);

    // Reset during SIGNAL
    $display("[TB] reset mid-operation");
    rst = 1'b1;
    tick();
    checkOutput("rst_irq", {31'h0, interrupt}, 32'h0);
    readCheck("rst_enable", 3'd0, 32'h0);
    readCheck("rst_mode", 3'd2, 32'h0);
    readCheck("rst_pending", 3'd1, 32'h0);
    readCheck("rst_info", 3'd5, 32'h0000_0801);
    rst = 1'b0;
    tick();
    checkOutput("rst_stays_low", {31'h0, interrupt}, 32'h0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
